// File: rtl/legv8_alu_pkg.sv
// Shared ALU encodings and the multiply sequencer state type.
// Used by the multiply sequencer and by anything else that drives the execute-stage ALU.
package legv8_alu_pkg;

  localparam int DATA_W = 64;
  localparam int ITER   = 64;
  localparam int CNT_W  = $clog2(ITER);

  // FS[4:2] selects the operation; FS[1]/FS[0] invert B/A.
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;
  localparam logic [4:0] FS_SUB = 5'b01010;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHL,
    SHR,
    FLAGS,
    DONE
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/response and ALU-issue signals of the multiply sequencer.
// The master modport is the parent side: it issues requests and hosts the ALU.
interface alu_mul_sequencer_if;
  import legv8_alu_pkg::*;

  logic              start;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] product;
  logic [3:0]        flags;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [4:0]        alu_fs;
  logic              alu_c0;
  logic [DATA_W-1:0] alu_f;
  logic [3:0]        alu_status;

  modport master (
    output start, op_a, op_b, alu_f, alu_status,
    input  busy, done, product, flags, alu_a, alu_b, alu_fs, alu_c0
  );

  modport slave (
    input  start, op_a, op_b, alu_f, alu_status,
    output busy, done, product, flags, alu_a, alu_b, alu_fs, alu_c0
  );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 64-bit multiplier that borrows the shared combinational ALU
// for every add and shift; one result per 195 cycles, low 64 product bits.
module alu_mul_sequencer
  import legv8_alu_pkg::*;
(
  input logic                clock,
  input logic                reset,
  alu_mul_sequencer_if.slave bus
);

  seq_state_e        state;
  seq_state_e        state_next;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] product_q;
  logic [3:0]        flags_q;

  logic last_iter;
  assign last_iter = (cnt == CNT_W'(ITER - 1));

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: default every combinational output first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = ADD;
      ADD:     state_next = SHL;
      SHL:     state_next = SHR;
      SHR:     state_next = last_iter ? FLAGS : ADD;
      FLAGS:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU drive depends only on state and registers, never on alu_f.
  always_comb begin
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_fs = FS_AND;
    bus.alu_c0 = 1'b0;
    bus.busy   = (state != IDLE);
    bus.done   = (state == DONE);
    unique case (state)
      ADD: begin
        bus.alu_a  = acc;
        bus.alu_b  = mplier[0] ? mcand : '0;
        bus.alu_fs = FS_ADD;
      end
      SHL: begin
        bus.alu_a  = mcand;
        bus.alu_b  = DATA_W'(1);
        bus.alu_fs = FS_LSL;
      end
      SHR: begin
        bus.alu_a  = mplier;
        bus.alu_b  = DATA_W'(1);
        bus.alu_fs = FS_LSR;
      end
      FLAGS: begin
        bus.alu_a  = acc;
        bus.alu_fs = FS_OR;
      end
      default: ;
    endcase
  end

  // Reset is checked first so it overrides a coincident start.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      product_q <= '0;
      flags_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= '0;
            mcand  <= bus.op_a;
            mplier <= bus.op_b;
            cnt    <= '0;
          end
        end
        ADD: acc <= bus.alu_f;
        SHL: mcand <= bus.alu_f;
        SHR: begin
          mplier <= bus.alu_f;
          if (!last_iter) cnt <= cnt + 1'b1;
        end
        FLAGS: begin
          product_q <= bus.alu_f;
          flags_q   <= {2'b00, bus.alu_status[ST_N], bus.alu_status[ST_Z]};
        end
        default: ;
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.flags   = flags_q;

endmodule
